// File: rtl/sdram_stream_dma_pkg.sv
// Shared encodings for the SDRAM stream DMA: controller commands, channel modes
// and scheduler states.
package sdram_pkg;

    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;

    localparam logic [1:0] MODE_RMW    = 2'd0;
    localparam logic [1:0] MODE_RDONLY = 2'd1;
    localparam logic [1:0] MODE_WRONLY = 2'd2;
    localparam logic [1:0] MODE_OFF    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

endpackage

// File: rtl/sdram_stream_dma_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last grant
// and wraps, so the most recently served channel has the lowest priority.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] i_Req,
    input  logic [CH_W-1:0]   i_Last,
    output logic [NUM_CH-1:0] o_Grant,
    output logic [CH_W-1:0]   o_Idx,
    output logic              o_Valid
);

    int w_cand;

    always_comb begin
        o_Grant = '0;
        o_Idx   = '0;
        o_Valid = 1'b0;
        w_cand  = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_cand = (int'(i_Last) + k) % NUM_CH;
            if (!o_Valid && i_Req[w_cand]) begin
                o_Valid         = 1'b1;
                o_Idx           = CH_W'(w_cand);
                o_Grant[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_stream_dma.sv
// Multi-channel SDRAM burst scheduler: round-robin grants fixed-length bursts
// between the SDRAM port and per-channel stream FIFOs over circular regions.
module sdram_stream_dma
    import sdram_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 22,
    parameter int BURST_W = 8,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        i_Clk,
    input  logic                        i_Reset,
    input  logic                        i_SDRAM_Requested,
    output logic                        o_SDRAM_Yield,
    output logic [1:0]                  o_Command,
    output logic [ADDR_W-1:0]           o_Data_Address,
    input  logic                        i_Data_Read_Valid,
    input  logic                        i_Data_Write_Done,
    output logic [CH_W-1:0]             o_Data_Sel,
    input  logic [2*NUM_CH-1:0]         i_Mode,
    input  logic [ADDR_W*NUM_CH-1:0]    i_Base_Addr,
    input  logic [ADDR_W*NUM_CH-1:0]    i_Region_Len,
    input  logic [BURST_W*NUM_CH-1:0]   i_Burst_Len,
    input  logic [NUM_CH-1:0]           i_Restart,
    input  logic [NUM_CH-1:0]           i_Rd_Fifo_Empty,
    input  logic [NUM_CH-1:0]           i_Wr_Fifo_Empty,
    input  logic [NUM_CH-1:0]           i_Wr_Fifo_Burst,
    output logic [NUM_CH-1:0]           o_Rd_Fifo_Wrreq,
    output logic [NUM_CH-1:0]           o_Wr_Fifo_Rdreq,
    output logic [NUM_CH-1:0]           o_Wrap
);

    state_t              r_state;
    logic [CH_W-1:0]     r_sel;
    logic [CH_W-1:0]     r_rr_ptr;
    logic [ADDR_W-1:0]   r_addr;
    logic [BURST_W-1:0]  r_cnt;
    logic [BURST_W-1:0]  r_blen;
    logic                r_adv;
    logic                r_pend;
    logic [ADDR_W-1:0]   r_offset [NUM_CH];
    logic                r_wrap   [NUM_CH];

    logic [NUM_CH-1:0]   w_wr_elig;
    logic [NUM_CH-1:0]   w_rd_elig;
    logic [NUM_CH-1:0]   w_req;
    logic [NUM_CH-1:0]   w_gnt_onehot;
    logic [CH_W-1:0]     w_gnt_idx;
    logic                w_gnt_valid;
    logic [ADDR_W-1:0]   w_g_base;
    logic [BURST_W-1:0]  w_g_blen;
    logic [1:0]          w_g_mode;
    logic                w_g_wr;
    logic                w_beat;
    logic                w_end;
    logic                w_restart_sel;
    logic [ADDR_W-1:0]   w_cur_len;
    logic [ADDR_W:0]     w_sum;
    logic                w_wrap_hit;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_elig
        logic [1:0]         w_m;
        logic [BURST_W-1:0] w_b;
        assign w_m = i_Mode[2*c +: 2];
        assign w_b = i_Burst_Len[BURST_W*c +: BURST_W];
        assign w_wr_elig[c] = (w_b != '0) && (w_m == MODE_RMW || w_m == MODE_WRONLY)
                              && i_Wr_Fifo_Burst[c];
        assign w_rd_elig[c] = (w_b != '0) &&
                              ((w_m == MODE_RMW && i_Rd_Fifo_Empty[c] && i_Wr_Fifo_Empty[c]) ||
                               (w_m == MODE_RDONLY && i_Rd_Fifo_Empty[c]));
        assign w_req[c] = w_wr_elig[c] | w_rd_elig[c];
    end

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .i_Req   (w_req),
        .i_Last  (r_rr_ptr),
        .o_Grant (w_gnt_onehot),
        .o_Idx   (w_gnt_idx),
        .o_Valid (w_gnt_valid)
    );

    assign w_g_base = i_Base_Addr[ADDR_W*w_gnt_idx +: ADDR_W];
    assign w_g_blen = i_Burst_Len[BURST_W*w_gnt_idx +: BURST_W];
    assign w_g_mode = i_Mode[2*w_gnt_idx +: 2];
    assign w_g_wr   = w_wr_elig[w_gnt_idx];

    assign w_beat = (r_state == ST_READ  && i_Data_Read_Valid) ||
                    (r_state == ST_WRITE && i_Data_Write_Done);
    assign w_end  = w_beat && (r_cnt == '0);
    assign w_restart_sel = r_pend | i_Restart[r_sel];

    // Region length is sampled live at end of burst; the wrap test uses one
    // extra bit so offset+burst never aliases below the region length.
    assign w_cur_len  = i_Region_Len[ADDR_W*r_sel +: ADDR_W];
    assign w_sum      = {1'b0, r_offset[r_sel]} + (ADDR_W+1)'(r_blen);
    assign w_wrap_hit = (w_sum >= {1'b0, w_cur_len});

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_state  <= ST_IDLE;
            r_sel    <= '0;
            r_rr_ptr <= CH_W'(NUM_CH - 1);
            r_addr   <= '0;
            r_cnt    <= '0;
            r_blen   <= '0;
            r_adv    <= 1'b0;
            r_pend   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_pend <= 1'b0;
                    if (!i_SDRAM_Requested && w_gnt_valid) begin
                        r_state  <= w_g_wr ? ST_WRITE : ST_READ;
                        r_sel    <= w_gnt_idx;
                        r_addr   <= w_g_base + r_offset[w_gnt_idx];
                        r_cnt    <= w_g_blen - BURST_W'(1);
                        r_blen   <= w_g_blen;
                        r_adv    <= w_g_wr || (w_g_mode == MODE_RDONLY);
                        r_rr_ptr <= w_gnt_idx;
                    end
                end
                ST_READ, ST_WRITE: begin
                    if (i_Restart[r_sel])
                        r_pend <= 1'b1;
                    if (w_beat) begin
                        r_addr <= r_addr + ADDR_W'(1);
                        r_cnt  <= r_cnt - BURST_W'(1);
                        if (r_cnt == '0)
                            r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A restart on the channel in flight is deferred to the burst's last beat
    // so the SDRAM address stream is never disturbed mid-burst.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        always_ff @(posedge i_Clk or posedge i_Reset) begin
            if (i_Reset) begin
                r_offset[c] <= '0;
                r_wrap[c]   <= 1'b0;
            end else begin
                r_wrap[c] <= 1'b0;
                if (w_end && r_sel == CH_W'(c)) begin
                    if (w_restart_sel) begin
                        r_offset[c] <= '0;
                    end else if (r_adv) begin
                        if (w_wrap_hit) begin
                            r_offset[c] <= '0;
                            r_wrap[c]   <= 1'b1;
                        end else begin
                            r_offset[c] <= w_sum[ADDR_W-1:0];
                        end
                    end
                end else if (i_Restart[c] && !(r_state != ST_IDLE && r_sel == CH_W'(c))) begin
                    r_offset[c] <= '0;
                end
            end
        end
        assign o_Wrap[c] = r_wrap[c];
    end

    always_comb begin
        case (r_state)
            ST_READ:  o_Command = CMD_READ;
            ST_WRITE: o_Command = CMD_WRITE;
            default:  o_Command = CMD_IDLE;
        endcase
    end

    assign o_SDRAM_Yield   = i_SDRAM_Requested && (r_state == ST_IDLE);
    assign o_Data_Address  = r_addr;
    assign o_Data_Sel      = r_sel;
    assign o_Rd_Fifo_Wrreq = (r_state == ST_READ  && i_Data_Read_Valid) ? (NUM_CH'(1) << r_sel) : '0;
    assign o_Wr_Fifo_Rdreq = (r_state == ST_WRITE && i_Data_Write_Done) ? (NUM_CH'(1) << r_sel) : '0;

endmodule

// File: tb/tb_sdram_stream_dma.sv
// Bench for sdram_stream_dma: eligibility table, directed multi-cycle sequences
// and a randomized run against a burst-level reference model.
module tb_sdram_stream_dma;
    import sdram_pkg::*;

    localparam int NCH = 4;
    localparam int AW  = 22;
    localparam int BW  = 8;
    localparam int CW  = 2;
    localparam int unsigned AMASK = (1 << AW) - 1;

    logic                 clk = 1'b0;
    logic                 rst, req, yield, rdv, wdone;
    logic [1:0]           cmd;
    logic [AW-1:0]        addr;
    logic [CW-1:0]        sel;
    logic [2*NCH-1:0]     mode_bus;
    logic [AW*NCH-1:0]    base_bus, len_bus;
    logic [BW*NCH-1:0]    bl_bus;
    logic [NCH-1:0]       restart, rde, wre, wrb, wrreq, rdreq, wrap;

    int n_err = 0;
    int n_chk = 0;

    int cf_mode [NCH];
    int unsigned cf_base [NCH];
    int unsigned cf_len  [NCH];
    int unsigned cf_bl   [NCH];

    always #5 clk = ~clk;

    sdram_stream_dma #(.NUM_CH(NCH), .ADDR_W(AW), .BURST_W(BW)) dut (
        .i_Clk             (clk),
        .i_Reset           (rst),
        .i_SDRAM_Requested (req),
        .o_SDRAM_Yield     (yield),
        .o_Command         (cmd),
        .o_Data_Address    (addr),
        .i_Data_Read_Valid (rdv),
        .i_Data_Write_Done (wdone),
        .o_Data_Sel        (sel),
        .i_Mode            (mode_bus),
        .i_Base_Addr       (base_bus),
        .i_Region_Len      (len_bus),
        .i_Burst_Len       (bl_bus),
        .i_Restart         (restart),
        .i_Rd_Fifo_Empty   (rde),
        .i_Wr_Fifo_Empty   (wre),
        .i_Wr_Fifo_Burst   (wrb),
        .o_Rd_Fifo_Wrreq   (wrreq),
        .o_Wr_Fifo_Rdreq   (rdreq),
        .o_Wrap            (wrap)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_ch(input int c, input int md, input int unsigned b,
                          input int unsigned l, input int unsigned bl);
        cf_mode[c] = md;
        cf_base[c] = b & AMASK;
        cf_len[c]  = l & AMASK;
        cf_bl[c]   = bl & 32'hFF;
        mode_bus[2*c +: 2]  = md[1:0];
        base_bus[AW*c +: AW] = b[AW-1:0];
        len_bus[AW*c +: AW]  = l[AW-1:0];
        bl_bus[BW*c +: BW]   = bl[BW-1:0];
    endtask

    // Holds reset for two cycles, checks reset values, releases at a falling edge.
    task automatic do_reset();
        rst = 1'b1; req = 1'b0; rdv = 1'b0; wdone = 1'b0;
        restart = '0; rde = '0; wre = '0; wrb = '0;
        for (int c = 0; c < NCH; c++) set_ch(c, 3, 0, 0, 0);
        @(negedge clk); #1;
        chk("rst cmd",   cmd,   CMD_IDLE);
        chk("rst addr",  addr,  0);
        chk("rst sel",   sel,   0);
        chk("rst wrap",  wrap,  0);
        chk("rst wrreq", wrreq, 0);
        chk("rst rdreq", rdreq, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits for a grant, then streams n beats checking address, select and FIFO
    // strobes; ends just after the falling edge of the first IDLE cycle.
    task automatic burst(input int ch, input bit wr, input int unsigned a0, input int n,
                         input bit exp_wrap, input int req_at, input int rs_at, input string nm);
        int t;
        t = 0;
        #1;
        while (cmd == CMD_IDLE && t < 40) begin
            @(negedge clk); #1; t++;
        end
        chk({nm, " cmd"}, cmd, wr ? CMD_WRITE : CMD_READ);
        chk({nm, " sel"}, sel, ch);
        for (int i = 0; i < n; i++) begin
            if (wr) wdone = 1'b1; else rdv = 1'b1;
            if (i == req_at) req = 1'b1;
            restart[ch] = (i == rs_at);
            #1;
            chk({nm, " addr"}, addr, (a0 + i) & AMASK);
            chk({nm, " fifo"}, wr ? rdreq : wrreq, 1 << ch);
            chk({nm, " cmd_busy"}, cmd, wr ? CMD_WRITE : CMD_READ);
            @(negedge clk); #1;
        end
        rdv = 1'b0; wdone = 1'b0; restart = '0;
        #1;
        chk({nm, " end_cmd"}, cmd, CMD_IDLE);
        chk({nm, " end_wrap"}, wrap[ch], exp_wrap);
    endtask

    typedef struct {
        int       md;
        bit       r_e, w_e, w_b;
        int       bl;
        logic [1:0] exp_cmd;
    } vec_t;

    vec_t vecs [10];

    // Reference model state: one burst at a time, tracked as remaining beats.
    int          m_st, m_ch, m_left, m_rr;
    int unsigned m_bl, m_addr;
    bit          m_adv, m_pend;
    int unsigned m_off [NCH];
    bit          m_wrap [NCH];

    function automatic bit m_wr_ok(input int c);
        return cf_bl[c] > 0 && (cf_mode[c] == 0 || cf_mode[c] == 2) && wrb[c];
    endfunction

    function automatic bit m_rd_ok(input int c);
        return cf_bl[c] > 0 && ((cf_mode[c] == 0 && rde[c] && wre[c]) ||
                                (cf_mode[c] == 1 && rde[c]));
    endfunction

    task automatic model_step();
        bit nw [NCH];
        int g;
        for (int c = 0; c < NCH; c++) nw[c] = 1'b0;
        if (m_st != 0) begin
            for (int c = 0; c < NCH; c++)
                if (restart[c]) begin
                    if (c != m_ch) m_off[c] = 0; else m_pend = 1'b1;
                end
            if ((m_st == 1 && rdv) || (m_st == 2 && wdone)) begin
                m_addr = (m_addr + 1) & AMASK;
                m_left--;
                if (m_left == 0) begin
                    if (m_pend) m_off[m_ch] = 0;
                    else if (m_adv) begin
                        if (m_off[m_ch] + m_bl >= cf_len[m_ch]) begin
                            m_off[m_ch] = 0; nw[m_ch] = 1'b1;
                        end else m_off[m_ch] = m_off[m_ch] + m_bl;
                    end
                    m_st = 0;
                end
            end
        end else begin
            g = -1;
            if (!req)
                for (int k = 1; k <= NCH; k++) begin
                    int c;
                    c = (m_rr + k) % NCH;
                    if (g < 0 && (m_wr_ok(c) || m_rd_ok(c))) g = c;
                end
            if (g >= 0) begin
                m_st   = m_wr_ok(g) ? 2 : 1;
                m_ch   = g;
                m_addr = (cf_base[g] + m_off[g]) & AMASK;
                m_bl   = cf_bl[g];
                m_left = cf_bl[g];
                m_adv  = m_wr_ok(g) || cf_mode[g] == 1;
                m_pend = 1'b0;
                m_rr   = g;
            end
            for (int c = 0; c < NCH; c++) if (restart[c]) m_off[c] = 0;
        end
        for (int c = 0; c < NCH; c++) m_wrap[c] = nw[c];
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [NCH-1:0] exp_wrap_v;
        int unsigned    blist [5];

        vecs[0] = '{0, 1, 1, 0, 8, CMD_READ};
        vecs[1] = '{0, 1, 0, 0, 8, CMD_IDLE};
        vecs[2] = '{0, 1, 0, 1, 8, CMD_WRITE};
        vecs[3] = '{0, 1, 1, 1, 8, CMD_WRITE};
        vecs[4] = '{1, 1, 0, 1, 8, CMD_READ};
        vecs[5] = '{1, 0, 1, 1, 8, CMD_IDLE};
        vecs[6] = '{2, 1, 1, 0, 8, CMD_IDLE};
        vecs[7] = '{2, 0, 0, 1, 8, CMD_WRITE};
        vecs[8] = '{3, 1, 1, 1, 8, CMD_IDLE};
        vecs[9] = '{0, 1, 1, 1, 0, CMD_IDLE};
        blist = '{0, 1, 3, 8, 16};

        rst = 1'b1; req = 1'b0; rdv = 1'b0; wdone = 1'b0;
        restart = '0; rde = '0; wre = '0; wrb = '0;
        mode_bus = '1; base_bus = '0; len_bus = '0; bl_bus = '0;

        // Eligibility table on channel 0
        for (int i = 0; i < 10; i++) begin
            do_reset();
            set_ch(0, vecs[i].md, 32'h5000, vecs[i].bl * 4, vecs[i].bl);
            rde[0] = vecs[i].r_e; wre[0] = vecs[i].w_e; wrb[0] = vecs[i].w_b;
            @(negedge clk); #1;
            chk($sformatf("elig[%0d] cmd", i), cmd, vecs[i].exp_cmd);
        end

        // RMW: read then write-back at the same address, then advance by one burst
        do_reset();
        set_ch(0, 0, 32'h20000, 32, 8);
        rde[0] = 1'b1; wre[0] = 1'b1;
        burst(0, 0, 32'h20000, 8, 0, -1, -1, "rmw_rd");
        rde[0] = 1'b0; wre[0] = 1'b0; wrb[0] = 1'b1;
        burst(0, 1, 32'h20000, 8, 0, -1, -1, "rmw_wr");
        burst(0, 1, 32'h20008, 8, 0, -1, -1, "rmw_wr2");

        // Read-only wrap over a two-burst region
        do_reset();
        set_ch(1, 1, 32'h100, 16, 8);
        rde[1] = 1'b1;
        burst(1, 0, 32'h100, 8, 0, -1, -1, "ro_b0");
        burst(1, 0, 32'h108, 8, 1, -1, -1, "ro_b1");
        burst(1, 0, 32'h100, 8, 0, -1, -1, "ro_b2");

        // Round-robin alternation, then yield while requested
        do_reset();
        set_ch(0, 1, 32'h1000, 8, 2);
        set_ch(2, 1, 32'h3000, 8, 2);
        rde = 4'b0101;
        burst(0, 0, 32'h1000, 2, 0, -1, -1, "rr0");
        burst(2, 0, 32'h3000, 2, 0, -1, -1, "rr1");
        burst(0, 0, 32'h1002, 2, 0, -1, -1, "rr2");
        burst(2, 0, 32'h3002, 2, 0, -1, -1, "rr3");
        req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("held cmd", cmd, CMD_IDLE);
            chk("held yield", yield, 1);
        end
        req = 1'b0;

        // Request raised mid-write: burst completes, then yield
        do_reset();
        set_ch(0, 2, 32'h400, 64, 8);
        wrb[0] = 1'b1;
        burst(0, 1, 32'h400, 8, 0, 3, -1, "req_mid");
        chk("req_mid yield", yield, 1);
        @(negedge clk); #1;
        chk("req_mid stays idle", cmd, CMD_IDLE);
        chk("req_mid yield2", yield, 1);
        req = 1'b0;

        // Restart during the final burst of the region overrides the wrap
        do_reset();
        set_ch(0, 2, 32'h800, 32, 8);
        wrb[0] = 1'b1;
        burst(0, 1, 32'h800, 8, 0, -1, -1, "rs_b0");
        burst(0, 1, 32'h808, 8, 0, -1, -1, "rs_b1");
        burst(0, 1, 32'h810, 8, 0, -1, -1, "rs_b2");
        burst(0, 1, 32'h818, 8, 0, -1, 4,  "rs_b3");
        burst(0, 1, 32'h800, 8, 0, -1, -1, "rs_b4");

        // Asynchronous reset mid-read, then the same burst re-issues from base
        do_reset();
        set_ch(0, 0, 32'h20000, 32, 8);
        rde[0] = 1'b1; wre[0] = 1'b1;
        @(negedge clk); #1;
        chk("arst grant", cmd, CMD_READ);
        for (int i = 0; i < 4; i++) begin
            rdv = 1'b1;
            @(negedge clk); #1;
        end
        rdv = 1'b0;
        chk("arst beat4 addr", addr, 32'h20004);
        rst = 1'b1;
        #1;
        chk("arst cmd", cmd, CMD_IDLE);
        chk("arst addr", addr, 0);
        @(negedge clk);
        rst = 1'b0;
        burst(0, 0, 32'h20000, 8, 0, -1, -1, "arst_reissue");

        // Randomized run against the reference model
        do_reset();
        m_st = 0; m_ch = 0; m_left = 0; m_rr = NCH - 1; m_bl = 0; m_addr = 0;
        m_adv = 1'b0; m_pend = 1'b0;
        for (int c = 0; c < NCH; c++) begin m_off[c] = 0; m_wrap[c] = 1'b0; end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 250 == 0)
                for (int c = 0; c < NCH; c++) begin
                    int unsigned bl, b;
                    bl = blist[$urandom_range(4, 0)];
                    b  = ($urandom_range(3, 0) == 0) ? (32'h3FFFF0 + $urandom_range(15, 0))
                                                     : ($urandom & AMASK);
                    set_ch(c, $urandom_range(3, 0), b, bl * $urandom_range(4, 1), bl);
                end
            req   = ($urandom_range(3, 0) == 0);
            rdv   = $urandom_range(1, 0);
            wdone = $urandom_range(1, 0);
            rde   = NCH'($urandom);
            wre   = NCH'($urandom);
            wrb   = NCH'($urandom);
            for (int c = 0; c < NCH; c++) restart[c] = ($urandom_range(39, 0) == 0);
            #1;
            for (int c = 0; c < NCH; c++) exp_wrap_v[c] = m_wrap[c];
            chk("rnd cmd",   cmd,   m_st);
            chk("rnd yield", yield, req && m_st == 0);
            chk("rnd wrreq", wrreq, (m_st == 1 && rdv)   ? (1 << m_ch) : 0);
            chk("rnd rdreq", rdreq, (m_st == 2 && wdone) ? (1 << m_ch) : 0);
            chk("rnd wrap",  wrap,  exp_wrap_v);
            if (m_st != 0) begin
                chk("rnd addr", addr, m_addr);
                chk("rnd sel",  sel,  m_ch);
            end
            model_step();
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
